// File: rtl/buf_tag_ctrl.sv
// rtl/buf_tag_ctrl.sv - tag lookup and allocation controller for a 4-entry buffer pool
//
// Purpose: checks each access tag against four stored tags. A hit returns the
// buffer number. A miss allocates a buffer, choosing a free entry first and
// otherwise the LRU victim supplied by the finder. It then runs a fill handshake
// with the memory side and returns the buffer number.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   acc_valid/acc_tag   access request in; acc_ready is high while IDLE
//   flush               invalidates all entries (IDLE only)
//   resp_valid/buf/hit  registered one-cycle response
//   lru_new_req         new-buffer request to the LRU finder (ALLOC only)
//   lru_ref_num         most recently used buffer, referenced by the finder
//   lru_replc           victim from the finder, valid the cycle after lru_new_req
//   fill_req/buf/tag    fill request to memory side, held until fill_ack
//   fill_evict/old_tag  victim held a valid tag, and that tag
//   fill_ack            fill complete pulse

module buf_tag_ctrl #(
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             acc_valid,
   input  logic [TAG_W-1:0] acc_tag,
   output logic             acc_ready,
   input  logic             flush,
   output logic             resp_valid,
   output logic [1:0]       resp_buf,
   output logic             resp_hit,
   output logic             lru_new_req,
   output logic [1:0]       lru_ref_num,
   input  logic [1:0]       lru_replc,
   output logic             fill_req,
   output logic [1:0]       fill_buf,
   output logic [TAG_W-1:0] fill_tag,
   output logic             fill_evict,
   output logic [TAG_W-1:0] fill_old_tag,
   input  logic             fill_ack
);

   typedef enum logic [2:0] {IDLE, LOOKUP, ALLOC, REPLC, FILL} state_t;

   state_t           state_q, state_d;
   logic [TAG_W-1:0] tag_q [4];
   logic [TAG_W-1:0] tag_d [4];
   logic [3:0]       valid_q, valid_d;
   logic [1:0]       mru_q, mru_d;
   logic [TAG_W-1:0] req_tag_q, req_tag_d;
   logic             resp_valid_q, resp_valid_d;
   logic [1:0]       resp_buf_q, resp_buf_d;
   logic             resp_hit_q, resp_hit_d;
   logic [1:0]       fill_buf_q, fill_buf_d;
   logic             fill_evict_q, fill_evict_d;
   logic [TAG_W-1:0] fill_old_tag_q, fill_old_tag_d;

   logic             hit;
   logic [1:0]       hit_idx;
   logic             free_any;
   logic [1:0]       free_idx;

   // Tags are unique among valid entries, so at most one match exists.
   // The free search runs downward so that the lowest free index wins.
   always_comb begin
      hit      = 1'b0;
      hit_idx  = 2'd0;
      free_any = 1'b0;
      free_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (valid_q[i] && (tag_q[i] == req_tag_q)) begin
            hit     = 1'b1;
            hit_idx = 2'(i);
         end
         if (!valid_q[i]) begin
            free_any = 1'b1;
            free_idx = 2'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!flush && acc_valid) state_d = LOOKUP;
         LOOKUP:  state_d = hit ? IDLE : (free_any ? FILL : ALLOC);
         ALLOC:   state_d = REPLC;
         REPLC:   state_d = FILL;
         FILL:    if (fill_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tag_d          = tag_q;
      valid_d        = valid_q;
      mru_d          = mru_q;
      req_tag_d      = req_tag_q;
      resp_valid_d   = 1'b0;
      resp_buf_d     = resp_buf_q;
      resp_hit_d     = resp_hit_q;
      fill_buf_d     = fill_buf_q;
      fill_evict_d   = fill_evict_q;
      fill_old_tag_d = fill_old_tag_q;
      case (state_q)
         IDLE: begin
            if (flush)          valid_d   = 4'b0000;
            else if (acc_valid) req_tag_d = acc_tag;
         end
         LOOKUP: begin
            if (hit) begin
               mru_d        = hit_idx;
               resp_valid_d = 1'b1;
               resp_hit_d   = 1'b1;
               resp_buf_d   = hit_idx;
            end else if (free_any) begin
               mru_d        = free_idx;
               fill_buf_d   = free_idx;
               fill_evict_d = 1'b0;
            end
         end
         REPLC: begin
            mru_d          = lru_replc;
            fill_buf_d     = lru_replc;
            fill_old_tag_d = tag_q[lru_replc];
            fill_evict_d   = 1'b1;
         end
         FILL: begin
            if (fill_ack) begin
               tag_d[fill_buf_q]   = req_tag_q;
               valid_d[fill_buf_q] = 1'b1;
               resp_valid_d        = 1'b1;
               resp_hit_d          = 1'b0;
               resp_buf_d          = fill_buf_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) tag_q[i] <= '0;
         valid_q        <= 4'b0000;
         mru_q          <= 2'b11;
         req_tag_q      <= '0;
         resp_valid_q   <= 1'b0;
         resp_buf_q     <= 2'd0;
         resp_hit_q     <= 1'b0;
         fill_buf_q     <= 2'd0;
         fill_evict_q   <= 1'b0;
         fill_old_tag_q <= '0;
      end else begin
         tag_q          <= tag_d;
         valid_q        <= valid_d;
         mru_q          <= mru_d;
         req_tag_q      <= req_tag_d;
         resp_valid_q   <= resp_valid_d;
         resp_buf_q     <= resp_buf_d;
         resp_hit_q     <= resp_hit_d;
         fill_buf_q     <= fill_buf_d;
         fill_evict_q   <= fill_evict_d;
         fill_old_tag_q <= fill_old_tag_d;
      end
   end

   // The finder references lru_ref_num on every edge without lru_new_req.
   // In REPLC the new victim therefore has to be presented directly, because
   // mru_q only picks it up at the end of that cycle.
   assign lru_ref_num  = (state_q == REPLC) ? lru_replc : mru_q;
   assign lru_new_req  = (state_q == ALLOC);
   assign acc_ready    = (state_q == IDLE);
   assign fill_req     = (state_q == FILL);
   assign fill_tag     = req_tag_q;
   assign fill_buf     = fill_buf_q;
   assign fill_evict   = fill_evict_q;
   assign fill_old_tag = fill_old_tag_q;
   assign resp_valid   = resp_valid_q;
   assign resp_buf     = resp_buf_q;
   assign resp_hit     = resp_hit_q;

endmodule

// File: tb/tb_buf_tag_ctrl.sv
// tb/tb_buf_tag_ctrl.sv - self-checking bench for buf_tag_ctrl
module tb_buf_tag_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       acc_valid, flush, fill_ack;
   logic [7:0] acc_tag;
   logic       acc_ready, resp_valid, resp_hit, lru_new_req, fill_req, fill_evict;
   logic [1:0] resp_buf, lru_ref_num, fill_buf;
   logic [1:0] lru_replc;
   logic [7:0] fill_tag, fill_old_tag;

   int total = 0;
   int bad   = 0;
   logic [2:0] exp_q [$];

   always #5 clk = ~clk;

   buf_tag_ctrl #(.TAG_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .acc_valid(acc_valid), .acc_tag(acc_tag), .acc_ready(acc_ready),
      .flush(flush),
      .resp_valid(resp_valid), .resp_buf(resp_buf), .resp_hit(resp_hit),
      .lru_new_req(lru_new_req), .lru_ref_num(lru_ref_num), .lru_replc(lru_replc),
      .fill_req(fill_req), .fill_buf(fill_buf), .fill_tag(fill_tag),
      .fill_evict(fill_evict), .fill_old_tag(fill_old_tag), .fill_ack(fill_ack)
   );

   // LRU finder model: ord[0] is oldest, ord[3] newest; reset order 0,1,2,3.
   logic [1:0] ord [4];
   always @(posedge clk or negedge rst_n) begin
      logic [1:0] t [4];
      int j;
      if (!rst_n) begin
         ord       <= '{2'd0, 2'd1, 2'd2, 2'd3};
         lru_replc <= 2'd0;
      end else if (lru_new_req) begin
         lru_replc <= ord[0];
      end else begin
         j = 0;
         for (int i = 0; i < 4; i++) begin
            if (ord[i] != lru_ref_num) begin
               t[j] = ord[i];
               j++;
            end
         end
         for (int i = j; i < 4; i++) t[i] = lru_ref_num;
         ord <= t;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One access; the expected response goes on the scoreboard when the request is driven.
   task automatic do_access(input logic [7:0] t, input logic [1:0] eb, input logic eh,
                            input logic ee, input logic [7:0] eo, input int ack_dly);
      int n;
      bit seen_new;
      logic [2:0] e;
      seen_new = 0;
      exp_q.push_back({eb, eh});
      @(negedge clk);
      acc_valid = 1'b1;
      acc_tag   = t;
      chk("acc_ready_idle", acc_ready, 1);
      @(negedge clk);
      acc_valid = 1'b0;
      acc_tag   = 8'($urandom);
      n = 1;
      while (!resp_valid && !fill_req && n < 60) begin
         if (lru_new_req) seen_new = 1;
         @(negedge clk);
         n++;
      end
      if (eh) begin
         chk("hit_latency", n, 2);
         chk("hit_no_fill", fill_req, 0);
      end else begin
         chk("fill_latency", n, ee ? 4 : 2);
         chk("fill_req", fill_req, 1);
         chk("fill_buf", fill_buf, eb);
         chk("fill_tag", fill_tag, t);
         chk("fill_evict", fill_evict, ee);
         if (ee) chk("fill_old_tag", fill_old_tag, eo);
         for (int k = 1; k < ack_dly; k++) begin
            @(negedge clk);
            chk("stall_fill_req", fill_req, 1);
            chk("stall_fill_buf", fill_buf, eb);
            chk("stall_fill_tag", fill_tag, t);
            chk("stall_acc_ready", acc_ready, 0);
         end
         fill_ack = 1'b1;
         @(negedge clk);
         fill_ack = 1'b0;
      end
      chk("lru_new_req_seen", seen_new, ee);
      chk("resp_valid", resp_valid, 1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bxxx;
      chk("resp_buf", resp_buf, e[2:1]);
      chk("resp_hit", resp_hit, e[0]);
      chk("lru_ref_after", lru_ref_num, eb);
      chk("acc_ready_after", acc_ready, 1);
      @(negedge clk);
      chk("resp_pulse_end", resp_valid, 0);
   endtask

   initial begin
      int n;
      rst_n = 1'b0; acc_valid = 1'b0; acc_tag = 8'h00; flush = 1'b0; fill_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_acc_ready", acc_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_buf", resp_buf, 0);
      chk("rst_resp_hit", resp_hit, 0);
      chk("rst_lru_new_req", lru_new_req, 0);
      chk("rst_lru_ref", lru_ref_num, 3);
      chk("rst_fill_req", fill_req, 0);
      chk("rst_fill_buf", fill_buf, 0);
      chk("rst_fill_tag", fill_tag, 0);
      chk("rst_fill_evict", fill_evict, 0);
      chk("rst_fill_old_tag", fill_old_tag, 0);
      rst_n = 1'b1;

      // Fill all four free entries in order.
      do_access(8'h0A, 2'd0, 1'b0, 1'b0, 8'h00, 3);
      do_access(8'h0B, 2'd1, 1'b0, 1'b0, 8'h00, 3);
      do_access(8'h0C, 2'd2, 1'b0, 1'b0, 8'h00, 3);
      do_access(8'h0D, 2'd3, 1'b0, 1'b0, 8'h00, 3);
      // Hits; order becomes 1,3,2,0.
      do_access(8'h0C, 2'd2, 1'b1, 1'b0, 8'h00, 0);
      do_access(8'h0A, 2'd0, 1'b1, 1'b0, 8'h00, 0);
      // LRU replacement of buffer 1 (tag 0x0B); order becomes 3,2,0,1.
      do_access(8'h0E, 2'd1, 1'b0, 1'b1, 8'h0B, 3);
      // 0x0B was evicted, so it misses and replaces buffer 3 (tag 0x0D).
      do_access(8'h0B, 2'd3, 1'b0, 1'b1, 8'h0D, 3);

      // Flush while full: 0x0D misses into free buffer 0, then hits.
      @(negedge clk); flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      do_access(8'h0D, 2'd0, 1'b0, 1'b0, 8'h00, 3);
      do_access(8'h0D, 2'd0, 1'b1, 1'b0, 8'h00, 0);

      // Long stall on fill_ack.
      do_access(8'h0F, 2'd1, 1'b0, 1'b0, 8'h00, 20);

      // Reset in the middle of a fill.
      @(negedge clk); acc_valid = 1'b1; acc_tag = 8'h10;
      @(negedge clk); acc_valid = 1'b0;
      n = 0;
      while (!fill_req && n < 20) begin @(negedge clk); n++; end
      chk("pre_rst_fill_req", fill_req, 1);
      chk("pre_rst_fill_buf", fill_buf, 2);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_fill_req", fill_req, 0);
      chk("midrst_acc_ready", acc_ready, 1);
      chk("midrst_lru_ref", lru_ref_num, 3);
      chk("midrst_fill_buf", fill_buf, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("postrst_acc_ready", acc_ready, 1);
      chk("postrst_lru_ref", lru_ref_num, 3);
      chk("postrst_fill_req", fill_req, 0);
      // All entries invalid again: 0x0A misses into buffer 0.
      do_access(8'h0A, 2'd0, 1'b0, 1'b0, 8'h00, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/buf_tag_ctrl.md
# buf_tag_ctrl

Tag-lookup and allocation controller for the 4-entry buffer pool. It is the initiator side of the LRU replacement finder. It accepts access requests carrying a tag and checks the tag against four stored buffer tags. On a hit it reports the buffer number to the LRU finder as a reference. On a miss it allocates a buffer (a free entry first, otherwise the LRU victim obtained through the finder's new-buffer request), runs a fill handshake with the memory side, and returns the buffer number to the requester.

## Interface
- TAG_W, 8, width of buffer tags
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- acc_valid  in  1  access request valid
- acc_tag  in  TAG_W  tag of requested data
- acc_ready  out  1  controller can accept a request (IDLE)
- flush  in  1  invalidate all entries (sampled in IDLE only)
- resp_valid  out  1  one-cycle response pulse
- resp_buf  out  2  buffer number holding the requested tag
- resp_hit  out  1  1 = hit, 0 = allocated/filled
- lru_new_req  out  1  to LRU finder new-buffer request
- lru_ref_num  out  2  to LRU finder referenced buffer number
- lru_replc  in  2  from LRU finder, buffer to replace (valid the cycle after lru_new_req)
- fill_req  out  1  fill request to memory side, held until fill_ack
- fill_buf  out  2  buffer being filled
- fill_tag  out  TAG_W  tag being fetched
- fill_evict  out  1  victim held a valid tag (write-back/notify)
- fill_old_tag  out  TAG_W  victim's previous tag, valid when fill_evict=1
- fill_ack  in  1  fill complete, one-cycle pulse

## Operation
- Storage: tag[0..3] (TAG_W each), valid[0..3], mru_q (2b), req_tag_q, state.
- LRU finder rule: the finder applies lru_ref_num as a reference on every clock edge where lru_new_req=0. Re-referencing the current MRU is harmless. lru_ref_num must therefore always present the most recently used buffer.
- lru_ref_num = lru_replc in REPLC, otherwise mru_q. This is combinational.
- lru_new_req = 1 only in ALLOC.
- States:
  - IDLE: acc_ready=1. flush=1 clears all valid bits and has priority over acc_valid; the request is not accepted that cycle. On acc_valid, capture acc_tag into req_tag_q and go to LOOKUP.
  - LOOKUP: compare req_tag_q against all entries with valid=1.
    - Hit at index i: mru_q<=i, resp (hit=1, buf=i), go to IDLE.
    - Miss with a free entry: pick the lowest-index entry with valid=0 as k. mru_q<=k, fill_buf<=k, fill_evict<=0, go to FILL.
    - Miss with all entries valid: go to ALLOC.
  - ALLOC: lru_new_req=1 for exactly one cycle, then REPLC.
  - REPLC: sample lru_replc as v. mru_q<=v, fill_buf<=v, fill_old_tag<=tag[v], fill_evict<=1, go to FILL.
  - FILL: fill_req=1, fill_tag=req_tag_q.
    - On fill_ack: tag[fill_buf]<=req_tag_q, valid<=1, resp (hit=0, buf=fill_buf), go to IDLE.
    - Without fill_ack: stay in FILL, all fill_* outputs stable.
- Tag matches are unique by construction. A tag is only allocated after it misses.
- flush outside IDLE is ignored.
- acc_valid outside IDLE is ignored. The requester holds it until acc_ready.

## Timing
- Reset values: valid=0000, mru_q=2'b11 (matches the finder's reset order, #3 newest), state=IDLE, acc_ready=1, resp_valid=0, resp_buf=0, resp_hit=0, lru_new_req=0, fill_req=0, fill_buf=0, fill_tag=0, fill_evict=0, fill_old_tag=0.
- resp_valid, resp_buf and resp_hit are registered. resp_valid is high for one cycle, the cycle after the LOOKUP hit or the fill_ack.
- Hit latency: request accepted at edge T, LOOKUP in cycle T+1, resp_valid in cycle T+2. acc_ready returns in T+2, so a new request may be accepted at that edge.
- Free-entry miss: fill_req rises 2 cycles after acceptance. resp_valid comes 1 cycle after fill_ack.
- LRU miss: ALLOC in cycle T+2, REPLC in T+3, fill_req from T+4.
- fill_ack outside FILL is ignored.
- Reset mid-operation: asynchronous return to the reset values, and any pending fill is abandoned. fill_req drops immediately on reset.

## Test plan
- After reset, access tags 0x0A, 0x0B, 0x0C, 0x0D, each with fill_ack 3 cycles after fill_req -> fill_buf 0, 1, 2, 3 respectively. fill_evict=0 for all. Each resp_hit=0 with the matching resp_buf.
- Access 0x0C -> resp_valid 2 cycles after acceptance, resp_hit=1, resp_buf=2, no fill_req. lru_ref_num=2 afterwards.
- From the state after the first scenario, access 0x0A (hit, buf 0), then 0x0E -> lru_new_req pulse, victim buffer 1, fill_old_tag=0x0B, fill_evict=1. resp_buf=1, resp_hit=0. A subsequent access to 0x0B misses.
- Assert flush in IDLE with entries full -> the next access to 0x0D misses and fills buffer 0 with fill_evict=0.
- Hold fill_ack low for 20 cycles -> fill_req, fill_buf and fill_tag stay stable, and acc_ready=0 throughout.
- Pulse rst_n low during FILL -> fill_req=0 immediately, valid=0000, lru_ref_num=3, acc_ready=1 after release.
